// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Request FSM states, request bundle and counter sizing.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int WAIT_CNT_W = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM built from four byte lanes.
// Synchronous per-lane write, combinational read of the addressed word.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic [AW-1:0]         addr,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  for (genvar l = 0; l < WORD_BYTES; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    // lane write; contents survive reset
    always_ff @(posedge clk) begin
      if (we[l]) mem[addr] <= wdata[8*l +: 8];
    end

    assign rdata[8*l +: 8] = mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request FSM with wait states.
// Optional DMEM_RANGE_CHECK_EN flags out-of-range addresses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
    WAIT_CNT_W'(WAIT_STATES - 1);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  req_t                  req_q, req_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  req_t        live;
  req_t        acc;
  logic        do_acc;
  logic        oor;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  assign live = '{req_we, req_adr, req_wdata, req_wmask};

  // WS=0 accesses straight from the port; otherwise from the capture
  assign acc = (state_q == WAIT) ? req_q : live;

`ifdef DMEM_RANGE_CHECK_EN
  logic unused_adr;
  assign unused_adr = ^acc.adr[1:0];
  assign oor = |acc.adr[31:AW+2];
`else
  logic unused_adr;
  assign unused_adr = ^{acc.adr[31:AW+2], acc.adr[1:0]};
  assign oor = 1'b0;
`endif

  assign ram_we = {4{do_acc & acc.we & ~oor}} & acc.wmask;

  dmem_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .addr (acc.adr[AW+1:2]),
    .we   (ram_we),
    .wdata(acc.wdata),
    .rdata(ram_rdata)
  );

  // next state, counter, capture and response data
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_acc    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d = live;
          if (WAIT_STATES == 0) begin
            do_acc  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          do_acc  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (do_acc) begin
      rdata_d = oor ? 32'h0 : ram_rdata;
      err_d   = oor;
    end
  end

  // state and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder with a byte-array memory model.
// Honors DMEM_RANGE_CHECK_EN when computing expectations.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [31:0] dmask;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m   [DEPTH];
  logic [3:0]  known_m [DEPTH];

  logic bp_hold = 1'b0;
  logic bp_val  = 1'b0;

  always @(posedge clk) begin
    #2;
    rsp_ready = bp_hold ? bp_val : 1'($urandom_range(0, 1));
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(logic we, logic [31:0] adr,
                                 logic [31:0] wd, logic [3:0] wm);
    exp_t e;
    int   idx;
    bit   inr;
    inr = 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
    inr = (adr < 32'(4 * DEPTH));
`endif
    idx = int'((adr / 4) % DEPTH);
    if (!inr) begin
      e.data  = 32'h0;
      e.dmask = 32'hFFFF_FFFF;
      e.err   = 1'b1;
      return e;
    end
    e.err  = 1'b0;
    e.data = mem_m[idx];
    for (int b = 0; b < 4; b++)
      e.dmask[8*b +: 8] = {8{known_m[idx][b]}};
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wm[b]) begin
          mem_m[idx][8*b +: 8] = wd[8*b +: 8];
          known_m[idx][b] = 1'b1;
        end
      end
    end
    return e;
  endfunction

  // scoreboard monitor: compare each completed response
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got rsp %h", rsp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata & e.dmask, e.data & e.dmask);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] adr,
                      input logic [31:0] wd, input logic [3:0] wm);
    int c;
    bit ok;
    @(posedge clk);
    #1;
    req_we = we; req_adr = adr; req_wdata = wd; req_wmask = wm;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout got 0 want 1");
      req_valid = 1'b0;
      return;
    end
    c = cyc;
    sb.push_back(model(we, adr, wd, wm));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_timeout got 0 want 1");
      return;
    end
    chk("latency", 32'(cyc), 32'(c + 1 + WS));
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout got 1 want 0");
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] adr,
                      input logic [31:0] wd, input logic [3:0] wm);
    send(we, adr, wd, wm);
    drain();
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]   = '0;
      known_m[i] = '0;
    end

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 32; i++)
      xact(1'b1, 32'(i * 4), $urandom, 4'hF);
    xact(1'b1, 32'h10, 32'h0, 4'hF);

    // reset in the middle of WAIT of a write
    @(posedge clk);
    #1;
    req_we = 1'b1; req_adr = 32'h10;
    req_wdata = 32'hDEAD_BEEF; req_wmask = 4'hF;
    req_valid = 1'b1;
    @(negedge clk);
    chk("mid_pre_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_hold", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    xact(1'b0, 32'h10, 32'h0, 4'h0);

    xact(1'b1, 32'h20, 32'h1122_3344, 4'hF);
    xact(1'b0, 32'h20, 32'h0, 4'hF);

    xact(1'b1, 32'h24, 32'hAABB_CCDD, 4'hF);
    xact(1'b1, 32'h24, 32'h00EE_0000, 4'b0100);
    xact(1'b0, 32'h24, 32'h0, 4'h0);
    xact(1'b1, 32'h24, 32'hFFFF_FFFF, 4'b0000);
    xact(1'b0, 32'h27, 32'h0, 4'hF);

    // backpressure on a read response
    xact(1'b1, 32'h28, 32'hCAFE_F00D, 4'hF);
    bp_val  = 1'b0;
    bp_hold = 1'b1;
    send(1'b0, 32'h28, 32'h0, 4'h0);
    held = rsp_rdata;
    chk("bp_rdata", held, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    req_we = 1'b0; req_adr = 32'h0; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_stable", rsp_rdata, held);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bp_val = 1'b1;
    @(negedge clk);
    chk("bp_ready_hs", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    bp_val = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_after_valid", 32'(rsp_valid), 32'd0);
    chk("bp_after_ready", 32'(req_ready), 32'd1);
    bp_hold = 1'b0;

    // addresses beyond the array
    xact(1'b0, 32'h0, 32'h0, 4'h0);
    xact(1'b1, 32'h1000, 32'h5566_7788, 4'hF);
    xact(1'b0, 32'h1000, 32'h0, 4'h0);
    xact(1'b0, 32'h0, 32'h0, 4'h0);

    for (int n = 0; n < 200; n++) begin
      a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        a = a | (32'($urandom_range(1, 7)) << 12);
      xact(1'($urandom_range(0, 1)), a, $urandom,
           4'($urandom_range(0, 15)));
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
